dmem_arbiter: RTL and testbench

//   Shares the single-port data memory between the CPU memory stage (port C) and a DMA/program-loader

---
 rtl/dmem_arbiter_if.sv | 25 ++
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request/address/data toward the
// arbiter, grant/stall/read-return back to the requester.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              stall;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, stall, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, stall, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin, burst-capped arbiter sharing the single-port data memory between the CPU
// memory stage and a DMA/loader port. Optional wait statistics under ARB_STATS_EN.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     cpu,
    dmem_arbiter_if.slave     dma,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [15:0]       cpu_wait_cnt,
    output logic [15:0]       dma_wait_cnt
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWN_C = 2'd1;
    localparam logic [1:0] OWN_D = 2'd2;

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last_d;     // 1: port D held the memory most recently
    logic [3:0] burst_cnt;  // saturates so a lone requester never wraps past the cap

    assign cpu.gnt   = (state == OWN_C);
    assign dma.gnt   = (state == OWN_D);
    assign cpu.stall = cpu.req & ~cpu.gnt;
    assign dma.stall = dma.req & ~dma.gnt;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cpu.req && (!dma.req || last_d)) state_nxt = OWN_C;
                else if (dma.req)                    state_nxt = OWN_D;
            end
            OWN_C: begin
                if (!cpu.req || (dma.req && burst_cnt == BURST_LAST))
                    state_nxt = dma.req ? OWN_D : IDLE;
            end
            OWN_D: begin
                if (!dma.req || (cpu.req && burst_cnt == BURST_LAST))
                    state_nxt = cpu.req ? OWN_C : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state     <= IDLE;
            last_d    <= 1'b1;
            burst_cnt <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state != IDLE) begin
                if (state_nxt != state) begin
                    last_d    <= (state == OWN_D);
                    burst_cnt <= 4'd0;
                end else if (burst_cnt != BURST_LAST) begin
                    burst_cnt <= burst_cnt + 4'd1;
                end
            end
        end
    end

    // Memory side follows the registered owner, so an async reset drops the access at once.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (state)
            OWN_C: begin
                mem_addr  = cpu.addr;
                mem_wdata = cpu.wdata;
                mem_read  = cpu.req & ~cpu.we;
                mem_write = cpu.req &  cpu.we;
            end
            OWN_D: begin
                mem_addr  = dma.addr;
                mem_wdata = dma.wdata;
                mem_read  = dma.req & ~dma.we;
                mem_write = dma.req &  dma.we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: read-data registers are reset too because their idle value of zero is visible at the ports.
        if (!rst) begin
            cpu.rvalid <= 1'b0;
            dma.rvalid <= 1'b0;
            cpu.rdata  <= '0;
            dma.rdata  <= '0;
        end else begin
            cpu.rvalid <= mem_read && (state == OWN_C);
            dma.rvalid <= mem_read && (state == OWN_D);
            if (mem_read && state == OWN_C) cpu.rdata <= mem_rdata;
            if (mem_read && state == OWN_D) dma.rdata <= mem_rdata;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_wait_cnt <= 16'd0;
            dma_wait_cnt <= 16'd0;
        end else if (stats_clr) begin
            cpu_wait_cnt <= 16'd0;
            dma_wait_cnt <= 16'd0;
        end else begin
            if (cpu.stall && cpu_wait_cnt != 16'hFFFF) cpu_wait_cnt <= cpu_wait_cnt + 16'd1;
            if (dma.stall && dma_wait_cnt != 16'hFFFF) dma_wait_cnt <= dma_wait_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic compared
// cycle by cycle with a tenure-based arbitration model and a shadow memory.
module tb_dmem_arbiter;

    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) cpu_if ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) dma_if ();

    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;
`ifdef ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] cpu_wait_cnt, dma_wait_cnt;
`endif

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu       (cpu_if),
        .dma       (dma_if),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
`ifdef ARB_STATS_EN
        ,
        .stats_clr    (stats_clr),
        .cpu_wait_cnt (cpu_wait_cnt),
        .dma_wait_cnt (dma_wait_cnt)
`endif
    );

    // 16-word memory, aliased on addr[5:2]; word i initialised to i.
    logic [31:0] tb_mem [16];
    logic        mem_init;
    assign mem_rdata = tb_mem[mem_addr[5:2]];
    always @(posedge clk) begin
        if (mem_init) for (int i = 0; i < 16; i++) tb_mem[i] <= 32'(i);
        else if (mem_write) tb_mem[mem_addr[5:2]] <= mem_wdata;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner 0=none 1=C 2=D, tenure length, last owner, shadow memory.
    int          m_own, m_last, m_run;
    logic        m_rv_c, m_rv_d;
    logic [31:0] m_rd_c, m_rd_d;
    logic [31:0] exp_mem [16];
    int          m_wait_c, m_wait_d;
    int          st_c, st_d;
    bit          done_c, done_d;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } port_req_t;

    port_req_t c_cur, d_cur;

    function automatic int idx(input logic [31:0] a);
        return int'(a[5:2]);
    endfunction

    task automatic model_reset();
        m_own = 0; m_last = 2; m_run = 0;
        m_rv_c = 1'b0; m_rv_d = 1'b0; m_rd_c = '0; m_rd_d = '0;
        m_wait_c = 0; m_wait_d = 0; st_c = 0; st_d = 0;
        done_c = 1'b0; done_d = 1'b0;
    endtask

    task automatic apply(input port_req_t c, input port_req_t d);
        cpu_if.req = c.req; cpu_if.we = c.we; cpu_if.addr = c.addr; cpu_if.wdata = c.wdata;
        dma_if.req = d.req; dma_if.we = d.we; dma_if.addr = d.addr; dma_if.wdata = d.wdata;
    endtask

    task automatic next_req(input port_req_t cur, input bit done, output port_req_t nxt);
        nxt = cur;
        if (!cur.req || done) begin
            nxt.req   = ($urandom_range(0, 3) != 0);
            nxt.we    = 1'($urandom_range(0, 1));
            nxt.addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            nxt.wdata = $urandom;
        end else if ($urandom_range(0, 19) == 0) begin
            nxt.req = 1'b0;
        end
    endtask

    // Compare one cycle against the model, advance the model, then move to the next negedge.
    task automatic step();
        logic cr, dr, mine, other;
        logic [31:0] e_addr;
        #1;
        cr = cpu_if.req;
        dr = dma_if.req;
        check("cpu_gnt",   cpu_if.gnt,   m_own == 1);
        check("dma_gnt",   dma_if.gnt,   m_own == 2);
        check("cpu_stall", cpu_if.stall, cr && m_own != 1);
        check("dma_stall", dma_if.stall, dr && m_own != 2);
        check("mem_read",  mem_read,  (m_own == 1 && cr && !cpu_if.we) || (m_own == 2 && dr && !dma_if.we));
        check("mem_write", mem_write, (m_own == 1 && cr &&  cpu_if.we) || (m_own == 2 && dr &&  dma_if.we));
        e_addr = (m_own == 1) ? cpu_if.addr : (m_own == 2) ? dma_if.addr : 32'd0;
        check("mem_addr", mem_addr, e_addr);
        if (m_own == 1) check("mem_wdata", mem_wdata, cpu_if.wdata);
        if (m_own == 2) check("mem_wdata", mem_wdata, dma_if.wdata);
        check("cpu_rvalid", cpu_if.rvalid, m_rv_c);
        check("dma_rvalid", dma_if.rvalid, m_rv_d);
        check("cpu_rdata",  cpu_if.rdata,  m_rd_c);
        check("dma_rdata",  dma_if.rdata,  m_rd_d);
        st_c = (cr && !cpu_if.gnt) ? st_c + 1 : 0;
        st_d = (dr && !dma_if.gnt) ? st_d + 1 : 0;
        if (cr) check("starve_c", 64'(st_c <= MAX_BURST + 1), 1);
        if (dr) check("starve_d", 64'(st_d <= MAX_BURST + 1), 1);
`ifdef ARB_STATS_EN
        check("cpu_wait_cnt", cpu_wait_cnt, m_wait_c);
        check("dma_wait_cnt", dma_wait_cnt, m_wait_d);
        if (stats_clr) begin
            m_wait_c = 0; m_wait_d = 0;
        end else begin
            if (cr && m_own != 1 && m_wait_c < 65535) m_wait_c++;
            if (dr && m_own != 2 && m_wait_d < 65535) m_wait_d++;
        end
`endif
        m_rv_c = 1'b0; m_rv_d = 1'b0;
        done_c = (m_own == 1) && cr;
        done_d = (m_own == 2) && dr;
        if (done_c) begin
            if (cpu_if.we) exp_mem[idx(cpu_if.addr)] = cpu_if.wdata;
            else begin m_rv_c = 1'b1; m_rd_c = exp_mem[idx(cpu_if.addr)]; end
        end
        if (done_d) begin
            if (dma_if.we) exp_mem[idx(dma_if.addr)] = dma_if.wdata;
            else begin m_rv_d = 1'b1; m_rd_d = exp_mem[idx(dma_if.addr)]; end
        end
        if (m_own == 0) begin
            if (cr && dr)  m_own = (m_last == 1) ? 2 : 1;
            else if (cr)   m_own = 1;
            else if (dr)   m_own = 2;
        end else begin
            mine  = (m_own == 1) ? cr : dr;
            other = (m_own == 1) ? dr : cr;
            m_run++;
            if (!mine || (other && m_run >= MAX_BURST)) begin
                m_last = m_own;
                m_run  = 0;
                m_own  = other ? 3 - m_own : 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        c_cur = '0; d_cur = '0;
        apply(c_cur, d_cur);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  waited;
        bit  got;
        bool_blk: begin end
        for (int i = 0; i < 16; i++) exp_mem[i] = 32'(i);
        rst = 1'b0;
        mem_init = 1'b1;
`ifdef ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        // Reset held with both ports requesting.
        c_cur = '{req: 1'b1, we: 1'b1, addr: 32'h20, wdata: 32'h1};
        d_cur = '{req: 1'b1, we: 1'b0, addr: 32'h40, wdata: 32'h2};
        apply(c_cur, d_cur);
        repeat (3) @(negedge clk);
        check("rst_cpu_gnt",    cpu_if.gnt,    0);
        check("rst_dma_gnt",    dma_if.gnt,    0);
        check("rst_cpu_rvalid", cpu_if.rvalid, 0);
        check("rst_dma_rvalid", dma_if.rvalid, 0);
        check("rst_mem_read",   mem_read,      0);
        check("rst_mem_write",  mem_write,     0);
        check("rst_mem_addr",   mem_addr,      0);
        check("rst_cpu_rdata",  cpu_if.rdata,  0);
        check("rst_cpu_stall",  cpu_if.stall,  1);
        mem_init = 1'b0;
        do_reset();

        // C read of 0x20 (word 8 holds 8).
        c_cur = '{req: 1'b1, we: 1'b0, addr: 32'h20, wdata: 32'h0};
        apply(c_cur, d_cur);
        #1 check("rd_stall_n", cpu_if.stall, 1);
        step();
        check("rd_gnt_n1",   cpu_if.gnt,   1);
        check("rd_mrd_n1",   mem_read,     1);
        check("rd_addr_n1",  mem_addr,     32'h20);
        check("rd_stall_n1", cpu_if.stall, 0);
        step();
        c_cur.req = 1'b0;
        apply(c_cur, d_cur);
        check("rd_rvalid_n2", cpu_if.rvalid, 1);
        check("rd_rdata_n2",  cpu_if.rdata,  32'h8);
        step();
        check("rd_rvalid_n3", cpu_if.rvalid, 0);
        check("rd_hold_n3",   cpu_if.rdata,  32'h8);

        // Both held from the first cycle after reset: C first, bursts of MAX_BURST.
        do_reset();
        c_cur = '{req: 1'b1, we: 1'b0, addr: 32'h40, wdata: 32'h0};
        d_cur = '{req: 1'b1, we: 1'b0, addr: 32'h08, wdata: 32'h0};
        apply(c_cur, d_cur);
        for (int k = 1; k <= 16; k++) begin
            step();
            check("burst_c", cpu_if.gnt, (((k - 1) / MAX_BURST) % 2) == 0);
            check("burst_d", dma_if.gnt, (((k - 1) / MAX_BURST) % 2) == 1);
        end

        // D write of 0xDEAD to 0x40 while C bursts reads of 0x40.
        d_cur.req = 1'b0;
        apply(c_cur, d_cur);
        repeat (3) step();
        d_cur = '{req: 1'b1, we: 1'b1, addr: 32'h40, wdata: 32'hDEAD};
        apply(c_cur, d_cur);
        got = 1'b0;
        waited = 0;
        while (!got && waited < 8) begin
            step();
            waited++;
            if (dma_if.gnt) got = 1'b1;
        end
        check("d_gnt_seen",    got, 1);
        check("d_gnt_latency", 64'(waited <= MAX_BURST), 1);
        check("d_wr_mem_write", mem_write, 1);
        check("d_wr_mem_addr",  mem_addr,  32'h40);
        check("d_wr_mem_wdata", mem_wdata, 32'hDEAD);
        step();
        d_cur.req = 1'b0;
        apply(c_cur, d_cur);
        #1 check("d_wr_one_cycle", mem_write, 0);
        step();
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (cpu_if.rvalid) got = 1'b1;
            else step();
        end
        check("readback_seen",  got,          1);
        check("readback_rdata", cpu_if.rdata, 32'hDEAD);

        // Async reset in the middle of a granted D write.
        c_cur.req = 1'b0;
        apply(c_cur, d_cur);
        repeat (6) step();
        d_cur = '{req: 1'b1, we: 1'b1, addr: 32'h0C, wdata: 32'h1234_5678};
        apply(c_cur, d_cur);
        step();
        check("mid_wr_gnt",   dma_if.gnt, 1);
        check("mid_wr_write", mem_write,  1);
        #2 rst = 1'b0;
        #1;
        check("async_dma_gnt",   dma_if.gnt, 0);
        check("async_mem_write", mem_write,  0);
        @(posedge clk);
        @(negedge clk);
        check("no_write", tb_mem[3], exp_mem[3]);
        do_reset();

`ifdef ARB_STATS_EN
        // D waits out a C burst, then the counters are cleared.
        c_cur = '{req: 1'b1, we: 1'b0, addr: 32'h10, wdata: 32'h0};
        apply(c_cur, d_cur);
        step();
        d_cur = '{req: 1'b1, we: 1'b0, addr: 32'h14, wdata: 32'h0};
        apply(c_cur, d_cur);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            if (dma_if.gnt) got = 1'b1;
        end
        check("stats_d_gnt",  got,          1);
        check("stats_d_wait", dma_wait_cnt, 16'd4);
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        check("stats_clr_c", cpu_wait_cnt, 0);
        check("stats_clr_d", dma_wait_cnt, 0);
        do_reset();
`endif

        // Randomized traffic, including withdrawals.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            next_req(c_cur, done_c, c_cur);
            next_req(d_cur, done_d, d_cur);
            apply(c_cur, d_cur);
`ifdef ARB_STATS_EN
            stats_clr = ($urandom_range(0, 49) == 0);
`endif
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
